// File: rtl/acoustics_pkg.sv
// acoustics_pkg: shared constants for the acoustics FPGA command path.
// Holds the receiver FSM state encoding, the default UART bit period,
// and the ASCII response bytes used by the command reader.
package acoustics_pkg;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;
    localparam int CLKS_PER_BIT_DEF = 868;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_1 = 8'h31;
endpackage

// File: rtl/uart_command_rx_sync_2ff.sv
// SYNC_2FF: generic single-bit two-flop synchroniser for asynchronous inputs.
// Ports: clk, reset (async, active-high), d_i (async input), q_o (synchronised output).
// RST_VAL sets the value both flops take during reset.
module SYNC_2FF #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RST_VAL;
            q_o    <= RST_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end
endmodule

// File: rtl/uart_command_rx.sv
// uart_command_rx: 8N1 UART receiver delivering the Command byte with a valid/ack handshake.
// Ports: clk, reset (async, active-high), Rx (raw serial line, idle high),
//        Command_Ack (consumer took Command), Command (last good byte),
//        Command_Valid, Framing_Error (pulse), Overrun (pulse), Busy (not IDLE).
module uart_command_rx
    import acoustics_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx,
    input  logic       Command_Ack,
    output logic [7:0] Command,
    output logic       Command_Valid,
    output logic       Framing_Error,
    output logic       Overrun,
    output logic       Busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_s;
    logic          rx_prev_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          stop_hit, load;

    SYNC_2FF #(.RST_VAL(1'b1)) u_sync (
        .clk  (clk),
        .reset(reset),
        .d_i  (Rx),
        .q_o  (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_prev_q <= 1'b1;
            cmd_q     <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_prev_q <= rx_s;
            cmd_q     <= cmd_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    // The bit-period counter restarts at every sample so each phase times from its own origin.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: if (rx_prev_q && !rx_s) begin
                state_d = START;
                cnt_d   = '0;
                bit_d   = '0;
            end
            START: if (cnt_q == HALF_LAST) begin
                cnt_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end else cnt_d = cnt_q + 1'b1;
            DATA: if (cnt_q == LAST) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end else cnt_d = cnt_q + 1'b1;
            STOP: if (cnt_q == LAST) begin
                cnt_d   = '0;
                state_d = rx_s ? IDLE : BREAK;
            end else cnt_d = cnt_q + 1'b1;
            BREAK: state_d = rx_s ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end

    // A load in the same cycle as an ack keeps Valid set: the new byte wins.
    always_comb begin
        stop_hit = (state_q == STOP) && (cnt_q == LAST);
        load     = stop_hit && rx_s;
        cmd_d    = load ? shift_q : cmd_q;
        valid_d  = load || (valid_q && !Command_Ack);
        ovr_d    = load && valid_q && !Command_Ack;
        ferr_d   = stop_hit && !rx_s;
    end

    assign Command       = cmd_q;
    assign Command_Valid = valid_q;
    assign Framing_Error = ferr_q;
    assign Overrun       = ovr_q;
    assign Busy          = state_q != IDLE;
endmodule

// File: doc/uart_command_rx.md
# uart_command_rx

Serial command receiver for the acoustics FPGA. It deserialises 8N1 UART frames from the host link into the 8-bit `Command` byte used by the command reader datapath, which uses `Command[3:0]` as the channel select. It presents each byte with a valid/acknowledge handshake and flags framing errors and overruns. It sits between the board RX pin and the command reader control FSM.

## Interface
- `CLKS_PER_BIT`, default 868: `clk` cycles per UART bit (100 MHz / 115200). Legal range is 4 or more.
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `Rx` input 1: raw serial line, asynchronous to `clk`, idle high.
- `Command_Ack` input 1: consumer has taken `Command`; sampled only while `Command_Valid`=1.
- `Command` output 8: last good received byte, held stable between loads.
- `Command_Valid` output 1: high from load until the cycle after `Command_Ack`.
- `Framing_Error` output 1: one-cycle pulse when a stop bit is sampled low.
- `Overrun` output 1: one-cycle pulse when a byte loads while `Command_Valid` is already 1 and no ack arrives that cycle.
- `Busy` output 1: high in every state except IDLE.

## Operation
- `Rx` passes through a 2-FF synchroniser, giving `rx_s`. `rx_s` resets to 1.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on a falling edge of `rx_s` (previous 1, current 0), go to START and clear the bit counter.
  - START: wait HALF = CLKS_PER_BIT/2 cycles (integer division), then sample. If `rx_s`=0, go to DATA. If `rx_s`=1, treat it as a glitch and return to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles, shift `rx_s` into the MSB of the shift register (LSB first on the wire). After bit 7, go to STOP.
  - STOP: wait CLKS_PER_BIT cycles, then sample. If 1, load `Command` from the shift register, set `Command_Valid`, and go to IDLE. If 0, pulse `Framing_Error`, leave `Command` unchanged, and go to BREAK.
  - BREAK: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line from retriggering.
- Handshake rules:
  - `Command_Valid` clears on the cycle after `Command_Ack`=1.
  - `Command_Ack` has no effect while `Command_Valid`=0.
  - Load and ack in the same cycle: the new byte wins, `Command_Valid` stays 1, and no `Overrun`.
  - Load while valid with no ack: overwrite `Command` with the newest byte, keep `Command_Valid`=1, and pulse `Overrun`.
- Reset values: `Command`=0x00, `Command_Valid`=0, `Framing_Error`=0, `Overrun`=0, `Busy`=0, FSM=IDLE, counters=0, shift register=0.
- Reset mid-frame aborts the frame with no output. After reset release, the receiver waits for a fresh falling edge.
- Bit-period counter width is clog2(CLKS_PER_BIT). The counter wraps to 0 at CLKS_PER_BIT-1 and is never allowed to overflow.

## Timing
- `Rx` to `rx_s` latency is 2 cycles.
- Let t0 be the cycle in which IDLE detects the falling edge of `rx_s`.
- Sample times:
  - Start bit sampled at t0+HALF.
  - Data bit i (i = 0..7) sampled at t0+HALF+(i+1)·CLKS_PER_BIT.
  - Stop bit sampled at t0+HALF+9·CLKS_PER_BIT.
- Outputs change registered, one cycle after the stop sample:
  - `Command`, `Command_Valid` and `Overrun` update on the cycle after the stop sample.
  - `Framing_Error` pulses on that cycle.
- `Busy` rises on t0+1 and falls on the cycle IDLE is re-entered.
- Back-to-back frames: a start edge arriving any time after the IDLE return is accepted. The minimum stop width tolerated is HALF cycles.
- Throughput is one byte per 10·CLKS_PER_BIT cycles. No flow control on `Rx`.

## Structure
- Shared package `acoustics_pkg` holds:
  - FSM state encoding (3-bit localparams IDLE..BREAK);
  - default `CLKS_PER_BIT`;
  - ASCII response constants 0x30 and 0x31, used by this block's testbench and by the command reader.
- Sub-module `SYNC_2FF`: a generic single-bit synchroniser with a reset-value parameter, reused for the other asynchronous inputs.
- The bit-period counter is inline.
- `GENERAL_COUNTER` is not reused here, because its terminal count must restart mid-frame.

## Test plan
All scenarios use CLKS_PER_BIT=16, so HALF=8.
- Nominal frame: frame 0x03, no ack. `Command`=0x03 and `Command_Valid`=1 at t0+153. Neither `Framing_Error` nor `Overrun` pulses. `Busy` is low from t0+153.
- Start glitch: `Rx` low for 4 cycles, then high. No state beyond START, `Command_Valid` stays 0, `Busy` returns to 0 by t0+9.
- Framing error: frame 0xA5 with stop bit 0 and the line held low for 40 cycles. `Framing_Error` is a single pulse at t0+153 and `Command` keeps its old value. No new start is detected until `Rx` goes high and then falls again.
- Overrun: frame 0x11 followed by 0x22, with no ack. The second load gives `Command`=0x22, `Command_Valid`=1 and a one-cycle `Overrun`. Then `Command_Ack`=1 for one cycle, and `Command_Valid`=0 on the next cycle.
- Ack on load cycle: hold `Command_Ack`=1 continuously while frame 0x5A is received. `Command` becomes 0x5A and `Command_Valid` pulses for exactly 1 cycle. No `Overrun`.
- Reset mid-frame: assert `reset` during data bit 4 of frame 0xFF. All outputs are at reset values immediately, with no `Command_Valid` afterward. A subsequent frame 0x07 is received correctly.
